serdes_link_scheduler: RTL and testbench

SERDES_LINK_SCHEDULER -- requirements
Module: serdes_link_scheduler

---
 rtl/serdes_link_scheduler.sv | 166 ++++++++++++++++
 tb/tb_serdes_link_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serdes_link_scheduler.sv
// Round-robin frame scheduler feeding an 8b/10b encoder: SOF/data/EOF framing with K-code fill.
// Define SCHED_IFG_EN to insert IFG_LEN K28.5 idle symbols after every EOF.
module serdes_link_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int IFG_LEN   = 2
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_n,
  input  logic [NUM_REQ-1:0]       i_Req,
  input  logic [NUM_REQ*8-1:0]     i_Data,
  input  logic [NUM_REQ-1:0]       i_Last,
  output logic [NUM_REQ-1:0]       o_Ack,
  input  logic                     i_Ser_Ready,
  output logic                     o_Valid,
  output logic [7:0]               o_Byte,
  output logic                     o_K,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_Grant_Id,
  output logic                     o_Busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;

`ifdef SCHED_IFG_EN
  typedef enum logic [2:0] {IDLE, SOF, DATA, EOF, IFG} state_t;
`else
  typedef enum logic [1:0] {IDLE, SOF, DATA, EOF} state_t;
`endif

  state_t          state, state_next;
  logic [GW-1:0]   pointer, pointer_next;
  logic [GW-1:0]   grant, grant_next;
  logic [CW-1:0]   burst_cnt, burst_next;
  logic            busy;
`ifdef SCHED_IFG_EN
  logic [3:0]      ifg_cnt, ifg_next;
`endif

  logic            transfer;
  logic            sel_req;
  logic            sel_last;
  logic [7:0]      sel_byte;
  logic            rr_found;
  logic [GW-1:0]   rr_pick;
  logic [GW-1:0]   cand [NUM_REQ];

  // Valid is simply "out of reset" so the very first edge after release can transfer.
  assign o_Valid    = i_Rst_n;
  assign transfer   = o_Valid & i_Ser_Ready;
  assign o_Grant_Id = grant;
  assign o_Busy     = busy;

  always_comb begin
    sel_req  = 1'b0;
    sel_last = 1'b0;
    sel_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == GW'(i)) begin
        sel_req  = i_Req[i];
        sel_last = i_Last[i];
        sel_byte = i_Data[8*i +: 8];
      end
    end
  end

  // Candidate order starts at the pointer and wraps; first requesting candidate wins.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i] = GW'((int'(pointer) + i) % NUM_REQ);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rr_found && i_Req[cand[i]]) begin
        rr_found = 1'b1;
        rr_pick  = cand[i];
      end
    end
  end

  always_comb begin
    state_next   = state;
    pointer_next = pointer;
    grant_next   = grant;
    burst_next   = burst_cnt;
    o_Byte       = K28_5;
    o_K          = 1'b1;
    o_Ack        = '0;
`ifdef SCHED_IFG_EN
    ifg_next     = ifg_cnt;
`endif
    case (state)
      IDLE: begin
        if (transfer && rr_found) begin
          grant_next = rr_pick;
          state_next = SOF;
        end
      end
      SOF: begin
        o_Byte = K27_7;
        if (transfer) state_next = DATA;
      end
      DATA: begin
        if (sel_req) begin
          o_Byte = sel_byte;
          o_K    = 1'b0;
          if (transfer) begin
            o_Ack      = NUM_REQ'(1) << grant;
            burst_next = burst_cnt + 1'b1;
            if (sel_last || (burst_cnt == CW'(MAX_BURST - 1))) state_next = EOF;
          end
        end
      end
      EOF: begin
        o_Byte = K29_7;
        if (transfer) begin
          pointer_next = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          burst_next   = '0;
`ifdef SCHED_IFG_EN
          ifg_next     = '0;
          state_next   = IFG;
`else
          state_next   = IDLE;
`endif
        end
      end
`ifdef SCHED_IFG_EN
      IFG: begin
        if (transfer) begin
          if (ifg_cnt == 4'(IFG_LEN - 1)) state_next = IDLE;
          else ifg_next = ifg_cnt + 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      pointer   <= '0;
      grant     <= '0;
      burst_cnt <= '0;
      busy      <= 1'b0;
`ifdef SCHED_IFG_EN
      ifg_cnt   <= '0;
`endif
    end else begin
      state     <= state_next;
      pointer   <= pointer_next;
      grant     <= grant_next;
      burst_cnt <= burst_next;
      busy      <= (state_next == SOF) || (state_next == DATA) || (state_next == EOF);
`ifdef SCHED_IFG_EN
      ifg_cnt   <= ifg_next;
`endif
    end
  end

endmodule

// File: tb/tb_serdes_link_scheduler.sv
// Directed scoreboard bench for serdes_link_scheduler (default parameters, 4 requesters, burst cap 4).
module tb_serdes_link_scheduler;

  typedef struct packed {
    logic       valid;
    logic [7:0] sym;
    logic       k;
    logic [3:0] ack;
    logic       busy;
    logic [1:0] grant;
  } exp_t;

`ifdef SCHED_IFG_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  last = '0;
  logic        ready = 1'b1;
  logic [3:0]  ack;
  logic        valid;
  logic [7:0]  sym;
  logic        k;
  logic [1:0]  grant;
  logic        busy;

  exp_t sb[$];
  int   test_count = 0;
  int   fail_count = 0;

  serdes_link_scheduler #(.NUM_REQ(4), .MAX_BURST(4), .IFG_LEN(2)) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .i_Req(req),
    .i_Data(data),
    .i_Last(last),
    .o_Ack(ack),
    .i_Ser_Ready(ready),
    .o_Valid(valid),
    .o_Byte(sym),
    .o_K(k),
    .o_Grant_Id(grant),
    .o_Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag);
    exp_t e;
    exp_t obs;
    obs = {valid, sym, k, ack, busy, grant};
    test_count++;
    if (sb.size() == 0) begin
      fail_count++;
      $error("[TB] FAIL %s: scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        fail_count++;
        $error("[TB] FAIL %s: observed valid=%b byte=%h k=%b ack=%b busy=%b grant=%0d, expected valid=%b byte=%h k=%b ack=%b busy=%b grant=%0d",
               tag, obs.valid, obs.sym, obs.k, obs.ack, obs.busy, obs.grant,
               e.valid, e.sym, e.k, e.ack, e.busy, e.grant);
      end
    end
  endtask

  task automatic expectNow(input string tag, input logic v, input logic [7:0] s, input logic kk,
                           input logic [3:0] a, input logic b, input logic [1:0] g);
    sb.push_back({v, s, kk, a, b, g});
    checkOutput(tag);
  endtask

  // One link cycle: drive just after the edge, predict, sample on the falling edge.
  task automatic applyStimulus(input string tag, input logic [3:0] r, input logic [3:0] l,
                               input logic rdy, input logic [31:0] d, input logic [7:0] s,
                               input logic kk, input logic [3:0] a, input logic b, input logic [1:0] g);
    @(posedge clk);
    #1;
    req   = r;
    last  = l;
    ready = rdy;
    data  = d;
    sb.push_back({1'b1, s, kk, a, b, g});
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic gapSteps(input logic [3:0] r, input logic [1:0] g);
    for (int i = 0; i < GAP; i++)
      applyStimulus("ifg_fill", r, 4'b0000, 1'b1, 32'h0, 8'hBC, 1'b1, 4'b0000, 1'b0, g);
  endtask

  initial begin
    #2;
    expectNow("reset_state", 1'b0, 8'hBC, 1'b1, 4'b0000, 1'b0, 2'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester, two-byte frame
    applyStimulus("single_idle", 4'b0001, 4'b0000, 1'b1, 32'h11, 8'hBC, 1'b1, 4'b0000, 1'b0, 2'd0);
    applyStimulus("single_sof",  4'b0001, 4'b0000, 1'b1, 32'h11, 8'hFB, 1'b1, 4'b0000, 1'b1, 2'd0);
    applyStimulus("single_d0",   4'b0001, 4'b0000, 1'b1, 32'h11, 8'h11, 1'b0, 4'b0001, 1'b1, 2'd0);
    applyStimulus("single_d1",   4'b0001, 4'b0001, 1'b1, 32'h22, 8'h22, 1'b0, 4'b0001, 1'b1, 2'd0);
    applyStimulus("single_eof",  4'b0000, 4'b0000, 1'b1, 32'h0,  8'hFD, 1'b1, 4'b0000, 1'b1, 2'd0);
    gapSteps(4'b0000, 2'd0);
    applyStimulus("single_end",  4'b0000, 4'b0000, 1'b1, 32'h0,  8'hBC, 1'b1, 4'b0000, 1'b0, 2'd0);

    // Burst cap: requester 1 never flags last
    applyStimulus("burst_idle", 4'b0010, 4'b0000, 1'b1, 32'h0, 8'hBC, 1'b1, 4'b0000, 1'b0, 2'd0);
    applyStimulus("burst_sof",  4'b0010, 4'b0000, 1'b1, 32'h0, 8'hFB, 1'b1, 4'b0000, 1'b1, 2'd1);
    for (int i = 0; i < 4; i++)
      applyStimulus("burst_data", 4'b0010, 4'b0000, 1'b1, {16'h0, 8'hA1 + 8'(i), 8'h00},
                    8'hA1 + 8'(i), 1'b0, 4'b0010, 1'b1, 2'd1);
    applyStimulus("burst_eof",  4'b0010, 4'b0000, 1'b1, 32'h0, 8'hFD, 1'b1, 4'b0000, 1'b1, 2'd1);
    gapSteps(4'b0010, 2'd1);
    applyStimulus("burst_end",  4'b0000, 4'b0000, 1'b1, 32'h0, 8'hBC, 1'b1, 4'b0000, 1'b0, 2'd1);

    // Reset clears the round-robin pointer
    @(posedge clk);
    #1 rst_n = 1'b0;
    req = 4'b0000;
    #1 expectNow("reset_ptr", 1'b0, 8'hBC, 1'b1, 4'b0000, 1'b0, 2'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round robin, all requesting, one-byte frames
    for (int f = 0; f < 5; f++) begin
      logic [1:0] g;
      logic [1:0] prev;
      g    = 2'(f % 4);
      prev = (f == 0) ? 2'd0 : 2'((f - 1) % 4);
      applyStimulus("rr_idle", 4'hF, 4'hF, 1'b1, 32'h33323130, 8'hBC, 1'b1, 4'b0000, 1'b0, prev);
      applyStimulus("rr_sof",  4'hF, 4'hF, 1'b1, 32'h33323130, 8'hFB, 1'b1, 4'b0000, 1'b1, g);
      applyStimulus("rr_data", 4'hF, 4'hF, 1'b1, 32'h33323130, 8'h30 + 8'(g), 1'b0,
                    4'b0001 << g, 1'b1, g);
      applyStimulus("rr_eof",  4'hF, 4'hF, 1'b1, 32'h33323130, 8'hFD, 1'b1, 4'b0000, 1'b1, g);
      gapSteps(4'hF, g);
    end

    // Stall and underrun on requester 2; requester 3 activity is noise
    applyStimulus("stall_idle", 4'b0100, 4'b0000, 1'b1, 32'h0, 8'hBC, 1'b1, 4'b0000, 1'b0, 2'd0);
    applyStimulus("stall_sof",  4'b1100, 4'b1000, 1'b1, 32'hEE000000, 8'hFB, 1'b1, 4'b0000, 1'b1, 2'd2);
    applyStimulus("stall_d0",   4'b1100, 4'b1000, 1'b1, 32'hEE510000, 8'h51, 1'b0, 4'b0100, 1'b1, 2'd2);
    for (int i = 0; i < 3; i++)
      applyStimulus("stall_hold", 4'b1100, 4'b1000, 1'b0, 32'hDD520000, 8'h52, 1'b0, 4'b0000, 1'b1, 2'd2);
    applyStimulus("stall_d1",   4'b1100, 4'b1000, 1'b1, 32'hEE520000, 8'h52, 1'b0, 4'b0100, 1'b1, 2'd2);
    for (int i = 0; i < 2; i++)
      applyStimulus("underrun_fill", 4'b1000, 4'b1000, 1'b1, 32'hEE990000, 8'hBC, 1'b1, 4'b0000, 1'b1, 2'd2);
    applyStimulus("stall_d2",   4'b1100, 4'b0100, 1'b1, 32'hEE530000, 8'h53, 1'b0, 4'b0100, 1'b1, 2'd2);
    applyStimulus("stall_eof",  4'b1100, 4'b0000, 1'b1, 32'h0, 8'hFD, 1'b1, 4'b0000, 1'b1, 2'd2);
    gapSteps(4'b1100, 2'd2);
    applyStimulus("stall_end",  4'b0000, 4'b0000, 1'b1, 32'h0, 8'hBC, 1'b1, 4'b0000, 1'b0, 2'd2);

    // Reset in the middle of a frame
    applyStimulus("abort_idle", 4'b0001, 4'b0000, 1'b1, 32'h61, 8'hBC, 1'b1, 4'b0000, 1'b0, 2'd2);
    applyStimulus("abort_sof",  4'b0001, 4'b0000, 1'b1, 32'h61, 8'hFB, 1'b1, 4'b0000, 1'b1, 2'd0);
    applyStimulus("abort_d0",   4'b0001, 4'b0000, 1'b1, 32'h61, 8'h61, 1'b0, 4'b0001, 1'b1, 2'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 expectNow("abort_reset", 1'b0, 8'hBC, 1'b1, 4'b0000, 1'b0, 2'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    req  = 4'b0001;
    data = 32'h71;
    last = 4'b0000;
    @(negedge clk);
    expectNow("release_idle", 1'b1, 8'hBC, 1'b1, 4'b0000, 1'b0, 2'd0);
    applyStimulus("release_sof", 4'b0001, 4'b0001, 1'b1, 32'h71, 8'hFB, 1'b1, 4'b0000, 1'b1, 2'd0);
    applyStimulus("release_d0",  4'b0001, 4'b0001, 1'b1, 32'h71, 8'h71, 1'b0, 4'b0001, 1'b1, 2'd0);
    applyStimulus("release_eof", 4'b0000, 4'b0000, 1'b1, 32'h0,  8'hFD, 1'b1, 4'b0000, 1'b1, 2'd0);
    gapSteps(4'b0000, 2'd0);
    applyStimulus("release_end", 4'b0000, 4'b0000, 1'b1, 32'h0,  8'hBC, 1'b1, 4'b0000, 1'b0, 2'd0);

    test_count++;
    assert (sb.size() == 0) else begin
      fail_count++;
      $error("[TB] FAIL scoreboard_drain: observed %0d leftover entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
